// File: rtl/nfu_2_accumulate.sv
// NFU-2 reduction: per-neuron pipelined adder tree over a Tn x Tn product tile,
// then a saturating cross-tile accumulator with a registered, narrowed output.
module nfu_2_accumulate #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int LOG2_TN   = 4,
    parameter int ACC_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic                          i_first,
    input  logic                          i_last,
    input  logic [BIT_WIDTH*Tn*Tn-1:0]    i_products,
    output logic                          o_valid,
    output logic [BIT_WIDTH*Tn-1:0]       o_sums,
    output logic [Tn-1:0]                 o_sat
);

    localparam int TW = BIT_WIDTH + LOG2_TN;

    localparam logic signed [ACC_WIDTH-1:0] A_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] A_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] N_MAX =
        {{(ACC_WIDTH-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] N_MIN =
        {{(ACC_WIDTH-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    // Level 0 is the unregistered input; level s holds Tn>>s partial sums per neuron.
    // Every level is kept at the final tree width; the upper bits are pure sign extension.
    for (genvar s = 0; s <= LOG2_TN; s++) begin : gen_lvl
        logic signed [TW-1:0] node [Tn][Tn>>s];
        if (s == 0) begin : gen_in
            for (genvar j = 0; j < Tn; j++) begin : gen_col
                for (genvar n = 0; n < Tn; n++) begin : gen_row
                    localparam int K = n * Tn + j;
                    assign node[j][n] = {{LOG2_TN{i_products[(K+1)*BIT_WIDTH-1]}},
                                         i_products[K*BIT_WIDTH +: BIT_WIDTH]};
                end
            end
        end else begin : gen_add
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int jj = 0; jj < Tn; jj++)
                        for (int nn = 0; nn < (Tn >> s); nn++)
                            node[jj][nn] <= '0;
                end else begin
                    for (int jj = 0; jj < Tn; jj++)
                        for (int nn = 0; nn < (Tn >> s); nn++)
                            node[jj][nn] <= gen_lvl[s-1].node[jj][2*nn] +
                                            gen_lvl[s-1].node[jj][2*nn+1];
                end
            end
        end
    end

    // Beat qualifiers ride alongside the tree; first/last only mean anything with valid.
    logic [LOG2_TN-1:0] vPipe, fPipe, lPipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vPipe <= '0;
            fPipe <= '0;
            lPipe <= '0;
        end else begin
            vPipe <= {vPipe[LOG2_TN-2:0], i_valid};
            fPipe <= {fPipe[LOG2_TN-2:0], i_valid & i_first};
            lPipe <= {lPipe[LOG2_TN-2:0], i_valid & i_last};
        end
    end

    logic accVld, accFirst, accLast;
    assign accVld   = vPipe[LOG2_TN-1];
    assign accFirst = fPipe[LOG2_TN-1];
    assign accLast  = lPipe[LOG2_TN-1];

    logic signed [ACC_WIDTH-1:0] acc     [Tn];
    logic signed [ACC_WIDTH-1:0] accNew  [Tn];
    logic signed [ACC_WIDTH-1:0] treeExt [Tn];
    logic        [ACC_WIDTH:0]   wide    [Tn];
    logic [Tn-1:0]               satFlag, satNew;
    logic                        empty, pendValid;

    always_comb begin
        for (int j = 0; j < Tn; j++) begin
            treeExt[j] = {{(ACC_WIDTH-TW){gen_lvl[LOG2_TN].node[j][0][TW-1]}},
                          gen_lvl[LOG2_TN].node[j][0]};
            wide[j]    = {acc[j][ACC_WIDTH-1], acc[j]} +
                         {treeExt[j][ACC_WIDTH-1], treeExt[j]};
            accNew[j]  = treeExt[j];
            satNew[j]  = 1'b0;
            if (!(accFirst || empty)) begin
                // Overflow when the two top bits of the one-bit-wider sum disagree.
                if (wide[j][ACC_WIDTH] != wide[j][ACC_WIDTH-1]) begin
                    accNew[j] = wide[j][ACC_WIDTH] ? A_MIN : A_MAX;
                    satNew[j] = 1'b1;
                end else begin
                    accNew[j] = wide[j][ACC_WIDTH-1:0];
                    satNew[j] = satFlag[j];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < Tn; j++) acc[j] <= '0;
            satFlag   <= '0;
            empty     <= 1'b1;
            pendValid <= 1'b0;
        end else begin
            pendValid <= accVld & accLast;
            if (accVld) begin
                for (int j = 0; j < Tn; j++) acc[j] <= accNew[j];
                satFlag <= satNew;
                empty   <= accLast;
            end
        end
    end

    // Narrowing reads the registered accumulator, so a following group's first
    // beat can overwrite acc on the same edge the finished group is published.
    logic [BIT_WIDTH-1:0] narrowed [Tn];
    logic [Tn-1:0]        narSat;

    always_comb begin
        for (int j = 0; j < Tn; j++) begin
            narSat[j]   = 1'b0;
            narrowed[j] = acc[j][BIT_WIDTH-1:0];
            if (acc[j] > N_MAX) begin
                narrowed[j] = N_MAX[BIT_WIDTH-1:0];
                narSat[j]   = 1'b1;
            end else if (acc[j] < N_MIN) begin
                narrowed[j] = N_MIN[BIT_WIDTH-1:0];
                narSat[j]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_sums  <= '0;
            o_sat   <= '0;
        end else begin
            o_valid <= pendValid;
            if (pendValid) begin
                for (int j = 0; j < Tn; j++) o_sums[j*BIT_WIDTH +: BIT_WIDTH] <= narrowed[j];
                o_sat <= satFlag | narSat;
            end
        end
    end

endmodule
